// File: rtl/sr_drive_sequencer.sv
// sr_drive_sequencer: debounces two raw request lines (SET_IN, CLR_IN) and
// turns their filtered rising edges into timed, mutually exclusive S/R drive
// pulses for a downstream SR flip-flop. It also tracks the expected flip-flop
// state (Q_EXP) and counts completed drives (EVT_CNT).
// Optional build macro SR_QCHECK_EN adds Q_FB/ERR, a sticky check of the real
// flip-flop output against Q_EXP during the GAP cycle.
module sr_drive_sequencer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_CYCLES    = 2,
  parameter int CNT_W           = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             SET_IN,
  input  logic             CLR_IN,
  output logic             S,
  output logic             R,
  output logic             BUSY,
  output logic             Q_EXP,
  output logic [CNT_W-1:0] EVT_CNT
`ifdef SR_QCHECK_EN
  ,
  input  logic             Q_FB,
  output logic             ERR
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE_S = 2'd1,
    DRIVE_R = 2'd2,
    GAP     = 2'd3
  } state_t;

  // Channel index 0 is the set path, index 1 the clear path.
  localparam int CH_SET = 0;
  localparam int CH_CLR = 1;

  localparam logic [7:0] DB_LAST    = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] PULSE_LAST = 4'(PULSE_CYCLES - 1);

  logic [1:0]      raw;
  logic [1:0]      sync1;
  logic [1:0]      sync2;
  logic [1:0]      filt;
  logic [1:0]      filt_d;
  logic [1:0][7:0] db_cnt;
  logic [1:0]      rise;
  logic [1:0]      pend;
  logic [1:0]      take;

  state_t          state;
  state_t          state_next;
  logic [3:0]      pulse_cnt;
  logic            drive_done;

  assign raw  = {CLR_IN, SET_IN};
  assign rise = filt & ~filt_d;

  // Two-flop synchronisers followed by a run-length debouncer per channel.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (!RST_N) begin
      sync1  <= '0;
      sync2  <= '0;
      filt   <= '0;
      filt_d <= '0;
      db_cnt <= '0;
    end else begin
      sync1  <= raw;
      sync2  <= sync1;
      filt_d <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != filt[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            filt[i]   <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 8'd1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // One-deep pending flags: filtered rising edges set them, the FSM consumes
  // them; an edge landing on the same cycle as its consume keeps the flag set.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pend <= '0;
    end else begin
      pend <= (pend & ~take) | rise;
    end
  end

  // Next-state logic: clear requests win over set requests when both wait.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    state_next = state;
    take       = '0;
    drive_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (pend[CH_CLR]) begin
          state_next   = DRIVE_R;
          take[CH_CLR] = 1'b1;
        end else if (pend[CH_SET]) begin
          state_next   = DRIVE_S;
          take[CH_SET] = 1'b1;
        end
      end
      DRIVE_S, DRIVE_R: begin
        if (pulse_cnt == PULSE_LAST) begin
          state_next = GAP;
          drive_done = 1'b1;
        end
      end
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register, pulse timer and registered drive/status outputs.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= IDLE;
      pulse_cnt <= '0;
      S         <= 1'b0;
      R         <= 1'b0;
      BUSY      <= 1'b0;
      Q_EXP     <= 1'b0;
      EVT_CNT   <= '0;
    end else begin
      state <= state_next;
      if (state_next != state) begin
        pulse_cnt <= '0;
      end else if (state == DRIVE_S || state == DRIVE_R) begin
        pulse_cnt <= pulse_cnt + 4'd1;
      end
      // S and R come from a single next-state value, so they are exclusive.
      S    <= (state_next == DRIVE_S);
      R    <= (state_next == DRIVE_R);
      BUSY <= (state_next != IDLE);
      if (drive_done) begin
        Q_EXP   <= (state == DRIVE_S);
        EVT_CNT <= EVT_CNT + CNT_W'(1);
      end
    end
  end

`ifdef SR_QCHECK_EN
  // Sticky mismatch flag: Q_EXP is already updated when GAP is entered.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ERR <= 1'b0;
    end else if (state == GAP && Q_FB != Q_EXP) begin
      ERR <= 1'b1;
    end
  end
`endif

endmodule
